// File: rtl/core_pkg.sv
// Shared core types: fetch FSM states and PC defaults.
// Used by the fetch unit and the branch unit.
package core_pkg;

  typedef enum logic [2:0] {
    S_START,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_HALT
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam int unsigned PC_STEP_DEF  = 4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch bus: imem request/valid read port and decode valid/ready port.
// master = fetch unit, slave = memory + decode side.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter: sync active-low reset, load enable, next-value
// mux (pc+PC_STEP / redir_pc). Ports: clk, rst, ld, sel_redir, redir_pc, pc.
module pc_reg #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              sel_redir,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] nxt;

  always_comb begin
    nxt = pc + ADDR_W'(PC_STEP);
    if (sel_redir) nxt = redir_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) pc <= RESET_PC;
    else if (ld) pc <= nxt;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC, reads imem, presents instr+pc to decode.
// Ports: clk, rst, bus (fetch bus master), redirect_en/pc, halt, halted, fetch_cnt.
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       PC_STEP  = PC_STEP_DEF,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus,
  input  logic                redirect_en,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                halt,
  output logic                halted,
  output logic [CNT_W-1:0]    fetch_cnt
);

  fetch_state_t state, nstate;

  logic              drop;
  logic [ADDR_W-1:0] pc;
  logic              pc_ld;
  logic              pc_redir;
  logic              vld_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] opc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rv;
  logic              take;
  logic              hs;

  assign rv = bus.imem_rvalid;

  // Data is kept only for a live read and no redirect this cycle.
  assign take = (state == S_WAIT) && rv && !drop && !redirect_en;
  assign hs   = (state == S_OUT) && bus.out_ready;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .ld        (pc_ld),
    .sel_redir (pc_redir),
    .redir_pc  (redirect_pc),
    .pc        (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_START;
    else state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_START: nstate = S_REQ;
      S_REQ:   nstate = S_WAIT;
      S_WAIT: begin
        if (rv) nstate = take ? S_OUT : S_REQ;
      end
      S_OUT: begin
        if (redirect_en) nstate = S_REQ;
        else if (bus.out_ready) nstate = halt ? S_HALT : S_REQ;
      end
      S_HALT:  nstate = S_HALT;
      default: nstate = S_START;
    endcase
  end

  always_comb begin
    bus.imem_req  = (state == S_REQ);
    bus.imem_addr = pc;
    halted        = (state == S_HALT);
    pc_redir      = redirect_en && (state != S_HALT);
    pc_ld         = pc_redir || take;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
      drop    <= 1'b0;
    end else begin
      if (take) begin
        vld_q   <= 1'b1;
        instr_q <= bus.imem_rdata;
        opc_q   <= pc;
      end else if (state == S_OUT && (redirect_en || bus.out_ready)) begin
        vld_q <= 1'b0;
      end
      if (hs && !redirect_en && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
      // A redirect while a read is in flight marks that read stale.
      if (state == S_REQ) begin
        drop <= redirect_en;
      end else if (state == S_WAIT) begin
        if (rv) drop <= 1'b0;
        else if (redirect_en) drop <= 1'b1;
      end
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_instr = instr_q;
  assign bus.out_pc    = opc_q;
  assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic,
// checked each cycle against a transaction-level fetch model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        halted0, halted1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

  assign if1.imem_rvalid = if0.imem_rvalid;
  assign if1.imem_rdata  = if0.imem_rdata;
  assign if1.out_ready   = if0.out_ready;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (if0.master),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted0),
    .fetch_cnt   (cnt0)
  );

  instr_fetch_unit #(.CNT_W(2)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .bus         (if1.master),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted1),
    .fetch_cnt   (cnt1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: pending request, outstanding read (maybe stale),
  // presented instruction, halted flag, accept count.
  bit          m_req, m_wait, m_stale, m_vld, m_halt;
  logic [31:0] m_pc, m_instr, m_opc;
  int          m_cnt;

  int          mem_cd = 0;
  int          g_lat  = 1;
  bit          g_fix  = 1'b0;
  bit          g_spur = 1'b0;
  logic [31:0] g_dat  = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_req = 0; m_wait = 0; m_stale = 0; m_vld = 0; m_halt = 0;
    m_pc = 32'h0; m_instr = 32'h0; m_opc = 32'h0; m_cnt = 0;
  endfunction

  function automatic void model_step(bit rv, logic [31:0] rd, bit rdr,
                                     logic [31:0] rpc, bit rdy, bit hl);
    if (m_halt) begin
    end else if (m_req) begin
      m_req = 0; m_wait = 1; m_stale = rdr;
      if (rdr) m_pc = rpc;
    end else if (m_wait) begin
      if (rv) begin
        m_wait = 0;
        if (m_stale || rdr) begin
          m_stale = 0; m_req = 1;
          if (rdr) m_pc = rpc;
        end else begin
          m_vld = 1; m_instr = rd; m_opc = m_pc; m_pc = m_pc + 32'd4;
        end
      end else if (rdr) begin
        m_stale = 1; m_pc = rpc;
      end
    end else if (m_vld) begin
      if (rdr) begin
        m_vld = 0; m_pc = rpc; m_req = 1;
      end else if (rdy) begin
        m_vld = 0; m_cnt++;
        if (hl) m_halt = 1;
        else m_req = 1;
      end
    end else begin
      m_req = 1;
      if (rdr) m_pc = rpc;
    end
  endfunction

  function automatic void compare_all();
    chk("imem_req", 32'(if0.imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", if0.imem_addr, m_pc);
    chk("out_valid", 32'(if0.out_valid), 32'(m_vld));
    chk("out_instr", if0.out_instr, m_instr);
    chk("out_pc", if0.out_pc, m_opc);
    chk("halted", 32'(halted0), 32'(m_halt));
    chk("fetch_cnt", 32'(cnt0), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
    chk("cnt_sat", 32'(cnt1), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    chk("sat_req", 32'(if1.imem_req), 32'(m_req));
  endfunction

  // Drive one cycle of inputs from the current negedge, then
  // advance to the next negedge and compare.
  task automatic tick(input bit rdy, input bit rdr, input logic [31:0] rpc,
                      input bit hl, input bit rstn = 1'b1);
    bit          rv;
    logic [31:0] rd;
    rv = 1'b0;
    rd = $urandom;
    if (mem_cd > 0) begin
      mem_cd--;
      if (mem_cd == 0) begin
        rv = 1'b1;
        rd = g_fix ? g_dat : $urandom;
      end
    end else if (g_spur && $urandom_range(0, 7) == 0) begin
      rv = 1'b1;
    end
    if (if0.imem_req === 1'b1)
      mem_cd = (g_lat == 0) ? int'($urandom_range(1, 3)) : g_lat;
    if (!rstn) mem_cd = 0;
    rst             = rstn;
    if0.imem_rvalid = rv;
    if0.imem_rdata  = rd;
    if0.out_ready   = rdy;
    redirect_en     = rdr;
    redirect_pc     = rpc;
    halt            = hl;
    if (!rstn) model_reset();
    else model_step(rv, rd, rdr, rpc, rdy, hl);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bit          rr, rd_en, hl, rs;
    logic [31:0] rpc;
    if0.imem_rvalid = 1'b0;
    if0.imem_rdata  = '0;
    if0.out_ready   = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state, first fetch at RESET_PC.
    tick(0, 1, 32'h40, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("rst_valid", 32'(if0.out_valid), 0);
    chk("rst_instr", if0.out_instr, 0);
    chk("rst_pc", if0.out_pc, 0);
    chk("rst_req", 32'(if0.imem_req), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    g_lat = 1; g_fix = 1; g_dat = 32'h00A00093;
    tick(1, 0, 0, 0);
    chk("t1_req", 32'(if0.imem_req), 1);
    chk("t1_addr", if0.imem_addr, 32'h0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("t1_valid", 32'(if0.out_valid), 1);
    chk("t1_instr", if0.out_instr, 32'h00A00093);
    chk("t1_opc", if0.out_pc, 32'h0);
    tick(1, 0, 0, 0);
    chk("t1_addr2", if0.imem_addr, 32'h4);
    chk("t1_cnt", 32'(cnt0), 1);

    // Decode stalls for 5 cycles.
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
    chk("t2_valid", 32'(if0.out_valid), 1);
    chk("t2_noreq", 32'(if0.imem_req), 0);
    chk("t2_opc", if0.out_pc, 32'h4);
    chk("t2_cnt", 32'(cnt0), 1);
    tick(1, 0, 0, 0);
    chk("t2_addr", if0.imem_addr, 32'h8);
    chk("t2_cnt2", 32'(cnt0), 2);

    // Redirect while waiting; the late data is dropped.
    g_lat = 3; g_dat = 32'hDEADBEEF;
    tick(1, 0, 0, 0);
    g_lat = 1; g_dat = 32'h00000013;
    tick(1, 1, 32'h100, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("t3_req", 32'(if0.imem_req), 1);
    chk("t3_addr", if0.imem_addr, 32'h100);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("t3_opc", if0.out_pc, 32'h100);
    chk("t3_instr", if0.out_instr, 32'h00000013);

    // Redirect and handshake together: squash, no count.
    tick(1, 1, 32'h200, 0);
    chk("t4_valid", 32'(if0.out_valid), 0);
    chk("t4_cnt", 32'(cnt0), 2);
    chk("t4_addr", if0.imem_addr, 32'h200);

    // Redirect in S_REQ to the top word, then wrap.
    tick(1, 1, 32'hFFFF_FFFC, 0);
    tick(1, 0, 0, 0);
    chk("t6_addr", if0.imem_addr, 32'hFFFF_FFFC);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("t6_opc", if0.out_pc, 32'hFFFF_FFFC);
    tick(1, 0, 0, 0);
    chk("t6_wrap", if0.imem_addr, 32'h0);
    chk("t6_cnt", 32'(cnt0), 3);
    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0);
    chk("t6_cnt5", 32'(cnt0), 5);
    chk("t6_sat", 32'(cnt1), 3);

    // Halt on handshake, then restart via reset.
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 1);
    chk("t5_halted", 32'(halted0), 1);
    for (int i = 0; i < 20; i++) begin
      tick(1, (i % 3) == 0, 32'h40, 1);
      chk("t5_noreq", 32'(if0.imem_req), 0);
    end
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("t5_restart", if0.imem_addr, 32'h0);
    chk("t5_unhalt", 32'(halted0), 0);

    // Random traffic.
    g_lat = 0; g_fix = 0; g_spur = 1;
    for (int i = 0; i < 3000; i++) begin
      rr    = ($urandom_range(0, 3) != 0);
      rd_en = ($urandom_range(0, 9) == 0);
      hl    = ($urandom_range(0, 39) == 0);
      rs    = m_halt ? ($urandom_range(0, 9) != 0)
                     : ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0)
        rpc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
      else
        rpc = $urandom & 32'hFFFF_FFFC;
      tick(rr, rd_en, rpc, hl, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-fetch stage of the multi-cycle RISC core. It sits directly upstream of the pipeline/state flip-flops that latch the fetched word for decode. It owns the program counter, issues word reads to instruction memory over a request/valid handshake, and presents each fetched instruction with its PC to decode via a valid/ready handshake. It supports branch/jump redirect and halt.

Parameters:
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, sequential PC increment (byte-addressed words)
CNT_W, 16, width of the retired-fetch counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
imem_req  out  1  one-cycle read strobe to instruction memory
imem_addr  out  ADDR_W  read address; valid while imem_req=1
imem_rvalid  in  1  read data valid; arrives 1..N cycles after imem_req
imem_rdata  in  DATA_W  read data, sampled when imem_rvalid=1
redirect_en  in  1  branch/jump taken; one-cycle pulse
redirect_pc  in  ADDR_W  redirect target
halt  in  1  stop fetching after the current instruction is accepted
out_valid  out  1  out_instr/out_pc valid to decode
out_ready  in  1  decode accepts the presented instruction
out_instr  out  DATA_W  fetched instruction (registered)
out_pc  out  ADDR_W  PC of out_instr (registered)
halted  out  1  block is in S_HALT
fetch_cnt  out  CNT_W  instructions accepted by decode, saturating

Behaviour:
- Reset (rst=0 at an edge): pc=RESET_PC, state=S_START, out_valid=0, out_instr=0, out_pc=0, imem_req=0, halted=0, fetch_cnt=0, drop=0. Reset has priority over all inputs, including mid-transaction; a late imem_rvalid after reset is ignored because the state is no longer S_WAIT.
- States:
  - S_START: the first cycle after reset. Go to S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc (combinational from state and pc). Go to S_WAIT.
  - S_WAIT: wait for imem_rvalid.
    - If rvalid and drop=0: out_instr<=rdata, out_pc<=pc, out_valid<=1, pc<=pc+PC_STEP (modulo 2^ADDR_W, wrap silently), go to S_OUT.
    - If rvalid and drop=1: discard the data, drop<=0, go to S_REQ.
  - S_OUT: out_valid=1, outputs held stable until the handshake.
    - On out_valid&out_ready: out_valid<=0, fetch_cnt increments (saturates at all-ones).
    - After the handshake, go to S_HALT if halt=1 in that cycle, else S_REQ.
    - With no handshake, stay in S_OUT.
  - S_HALT: halted=1, no requests issued. Exit only through reset.
- Minimum latency: S_REQ to out_valid is 2 cycles when rvalid returns the cycle after the request. Steady-state throughput is one instruction per 3 cycles with immediate ready.
- Redirect (redirect_en=1) in S_REQ, S_OUT or S_START:
  - pc<=redirect_pc, out_valid<=0 (a presented instruction is squashed and not counted), go to S_REQ.
  - In S_REQ, the request issued this cycle is to the old pc. Go to S_WAIT with drop<=1.
- Redirect in S_WAIT: pc<=redirect_pc.
  - If rvalid=0 in the same cycle: drop<=1, stay in S_WAIT.
  - If rvalid=1 in the same cycle: discard the data, go to S_REQ.
- Redirect in S_HALT: ignored.
- Redirect and handshake in the same S_OUT cycle: redirect wins; the instruction is squashed and not counted.
- imem_rvalid outside S_WAIT: ignored.
- halt is sampled only on the S_OUT handshake cycle.
- imem_req is never asserted in two consecutive cycles. At most one read is outstanding.

Decomposition:
- Shared package core_pkg: fetch state enum {S_START, S_REQ, S_WAIT, S_OUT, S_HALT}; constants RESET_PC_DEF and PC_STEP_DEF, shared with the branch unit.
- One natural sub-module: pc_reg. It is an ADDR_W-wide register with sync active-low reset to RESET_PC, load enable, and a next-value mux (increment / redirect). It is built in the same style as the core's existing flip-flop cells.
- The FSM and the output registers stay in the top module.

Test Plan:
1. Reset, then a memory returning rdata=32'h00A00093 one cycle after each req, out_ready=1 -> first imem_addr=0; out_valid in cycle 3 after reset release with out_pc=0; next req addr=4; fetch_cnt=1 after the handshake.
2. out_ready held low for 5 cycles while out_valid=1 -> out_instr/out_pc stable, no imem_req, fetch_cnt unchanged; ready high -> single count, next req addr=pc+4.
3. redirect_en with redirect_pc=32'h100 while in S_WAIT, with rvalid arriving 2 cycles later carrying 32'hDEADBEEF -> that data is never presented; the next imem_addr is 32'h100.
4. redirect in the same S_OUT cycle as out_ready -> out_valid falls, fetch_cnt is not incremented, next req addr = redirect_pc.
5. halt=1 on a handshake -> halted=1 next cycle, no further imem_req for 20 cycles, redirect ignored; rst low for one cycle -> pc=0, restart at addr 0.
6. Start from pc=32'hFFFF_FFFC (via redirect), with rvalid arriving -> out_pc=32'hFFFF_FFFC, next req addr=0 (wrap). Also check fetch_cnt saturation with CNT_W=2 after 5 accepts -> 3.
